uart_tx_fifo: RTL

//  Byte FIFO and launch scheduler directly upstream of the UART transmitter.

---
 rtl/uart_tx_fifo_if.sv | 38 +++
 rtl/uart_tx_fifo.sv | 109 ++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer and transmitter-side signal bundle for uart_tx_fifo
// flush is present only when UART_TX_FIFO_FLUSH_EN is defined.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    full;
  logic                    empty;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;
  logic                    launch_err;
  logic                    tx_start;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_busy;
`ifdef UART_TX_FIFO_FLUSH_EN
  logic                    flush;

  modport master (
    output wr_en, wr_data, tx_busy, flush,
    input  full, empty, level, overflow, launch_err, tx_start, tx_data
  );
  modport slave (
    input  wr_en, wr_data, tx_busy, flush,
    output full, empty, level, overflow, launch_err, tx_start, tx_data
  );
`else
  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, level, overflow, launch_err, tx_start, tx_data
  );
  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, level, overflow, launch_err, tx_start, tx_data
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and one-in-flight launch scheduler for the UART transmitter
// Optional flush port enabled by defining UART_TX_FIFO_FLUSH_EN.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_q, level_nx;
  logic                  full_q, empty_q, overflow_q, launch_err_q, tx_start_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [CW-1:0]         busy_cnt;
  logic                  flush_i, push, pop, timeout, start_d, err_d;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign flush_i = bus.flush;
`else
  assign flush_i = 1'b0;
`endif

  assign timeout = (busy_cnt == CW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (!empty_q && !bus.tx_busy && !flush_i) state_nx = START;
      START:     state_nx = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy) state_nx = WAIT_DONE;
                 else if (timeout) state_nx = IDLE;
      WAIT_DONE: if (!bus.tx_busy) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // A pop at the same time as a write to a full FIFO does not free space for it.
  always_comb begin
    push     = bus.wr_en && !full_q && !flush_i;
    pop      = (state == IDLE) && !empty_q && !bus.tx_busy && !flush_i;
    start_d  = (state == START);
    err_d    = (state == WAIT_BUSY) && !bus.tx_busy && timeout;
    level_nx = level_q;
    if (push && !pop)      level_nx = level_q + LW'(1);
    else if (pop && !push) level_nx = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      launch_err_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_cnt     <= '0;
    end else begin
      if (flush_i) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
        full_q  <= 1'b0;
        empty_q <= 1'b1;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        level_q <= level_nx;
        full_q  <= (level_nx == LW'(DEPTH));
        empty_q <= (level_nx == '0);
      end
      if (pop) tx_data_q <= mem[rd_ptr];
      overflow_q   <= bus.wr_en && full_q && !flush_i;
      launch_err_q <= err_d;
      tx_start_q   <= start_d;
      if (state == START)                         busy_cnt <= '0;
      else if (state == WAIT_BUSY && !bus.tx_busy) busy_cnt <= busy_cnt + CW'(1);
    end
  end

  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.level      = level_q;
  assign bus.overflow   = overflow_q;
  assign bus.launch_err = launch_err_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
endmodule
